scope_capture: RTL

Triggered acquisition stage that sits directly upstream of the display frame buffer. It accepts a stream of ADC samples and waits for a rising-edge crossing of the trigger level, which is the same level the on-screen trigger marker shows. It then captures one screen width of samples into an internal buffer and replays them as (x, y) pixel writes to the display RAM write port under a valid/ready handshake.

---
 rtl/scope_capture_if.sv | 13 +
 rtl/scope_capture.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/scope_capture_if.sv
// Pixel write port toward the display frame buffer: one (x, y) beat per valid/ready transfer.
interface scope_capture_if #(
    parameter int X_W      = 10,
    parameter int SAMPLE_W = 9
);
    logic                o_wr_valid;
    logic [X_W-1:0]      o_wr_x;
    logic [SAMPLE_W-1:0] o_wr_y;
    logic                i_wr_ready;

    modport master (output o_wr_valid, output o_wr_x, output o_wr_y, input i_wr_ready);
    modport slave  (input o_wr_valid, input o_wr_x, input o_wr_y, output i_wr_ready);
endinterface

// File: rtl/scope_capture.sv
// Triggered scope acquisition: wait for a rising crossing (or auto timeout), capture DEPTH
// samples into block RAM, then replay them as column-ordered pixel writes.
module scope_capture #(
    parameter int SAMPLE_W     = 9,
    parameter int DEPTH        = 640,
    parameter int X_W          = 10,
    parameter int AUTO_TIMEOUT = 100000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [SAMPLE_W-1:0] i_trigger_level,
    input  logic                i_arm,
    input  logic                i_continuous,
    input  logic                i_auto,
    scope_capture_if.master     io_wr,
    output logic                o_busy,
    output logic                o_triggered,
    output logic                o_done
);
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam int RX_W  = X_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;

    state_t              r_state, w_state_nxt;
    logic [SAMPLE_W-1:0] r_prev;
    logic                r_prev_vld;
    logic [TMO_W-1:0]    r_tmo;
    logic [X_W-1:0]      r_widx;
    logic [RX_W-1:0]     r_ridx;
    logic                r_rd_vld;
    logic [X_W-1:0]      r_rd_x;
    logic [SAMPLE_W-1:0] r_rdata;
    logic                r_wr_valid;
    logic [X_W-1:0]      r_wr_x;
    logic [SAMPLE_W-1:0] r_wr_y;
    logic                r_triggered;
    logic                r_done;
    logic [SAMPLE_W-1:0] r_mem [DEPTH];

    logic           w_samp_wait, w_cross, w_force, w_trig;
    logic           w_cap_wr, w_cap_last, w_xfer, w_last_xfer, w_rearm;
    logic           w_o_adv, w_o_load, w_rd_en, w_mem_we;
    logic [X_W-1:0] w_addr;

    assign w_samp_wait = (r_state == WAIT_TRIG) && i_sample_valid;
    assign w_cross     = r_prev_vld && (r_prev < i_trigger_level) && (i_sample >= i_trigger_level);
    assign w_force     = i_auto && (r_tmo >= TMO_W'(AUTO_TIMEOUT)) && !w_cross;
    assign w_trig      = w_samp_wait && (w_cross || w_force);
    assign w_cap_wr    = (r_state == CAPTURE) && i_sample_valid;
    assign w_cap_last  = w_cap_wr && (r_widx == X_W'(DEPTH - 1));
    assign w_xfer      = r_wr_valid && io_wr.i_wr_ready;
    assign w_last_xfer = (r_state == READOUT) && w_xfer && (r_wr_x == X_W'(DEPTH - 1));
    assign w_rearm     = ((r_state == IDLE) && i_arm) || (w_last_xfer && i_continuous);

    // Two-deep read pipeline (RAM data reg + output reg) so a stall never costs a bubble.
    assign w_o_adv  = !r_wr_valid || io_wr.i_wr_ready;
    assign w_o_load = (r_state == READOUT) && r_rd_vld && w_o_adv;
    assign w_rd_en  = (r_state == READOUT) && (r_ridx < RX_W'(DEPTH)) && (!r_rd_vld || w_o_load);
    assign w_mem_we = w_trig || w_cap_wr;
    assign w_addr   = (r_state == CAPTURE) ? r_widx :
                      (r_state == READOUT) ? r_ridx[X_W-1:0] : '0;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_addr] <= i_sample;
        if (w_rd_en)  r_rdata       <= r_mem[w_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (i_arm)       w_state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (w_trig)      w_state_nxt = CAPTURE;
            CAPTURE:   if (w_cap_last)  w_state_nxt = READOUT;
            READOUT:   if (w_last_xfer) w_state_nxt = i_continuous ? WAIT_TRIG : IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy           = (r_state != IDLE);
        o_triggered      = r_triggered;
        o_done           = r_done;
        io_wr.o_wr_valid = r_wr_valid;
        io_wr.o_wr_x     = r_wr_x;
        io_wr.o_wr_y     = r_wr_y;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
            r_tmo       <= '0;
            r_widx      <= '0;
            r_ridx      <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_x      <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_xfer;

            if (w_rearm) begin
                r_prev_vld <= 1'b0;
                r_tmo      <= '0;
            end else if (w_samp_wait) begin
                r_prev     <= i_sample;
                r_prev_vld <= 1'b1;
                if (i_auto && !w_trig) r_tmo <= r_tmo + 1'b1;
            end

            if (w_trig) begin
                r_widx      <= X_W'(1);
                r_triggered <= w_cross;
            end else if (w_cap_wr) begin
                r_widx <= r_widx + 1'b1;
            end

            if (w_cap_last) begin
                r_ridx   <= '0;
                r_rd_vld <= 1'b0;
            end else if (w_rd_en) begin
                r_ridx   <= r_ridx + 1'b1;
                r_rd_x   <= r_ridx[X_W-1:0];
                r_rd_vld <= 1'b1;
            end else if (w_o_load) begin
                r_rd_vld <= 1'b0;
            end

            if (w_o_load) begin
                r_wr_valid <= 1'b1;
                r_wr_x     <= r_rd_x;
                r_wr_y     <= r_rdata;
            end else if (w_xfer) begin
                r_wr_valid <= 1'b0;
            end
        end
    end
endmodule
